// File: rtl/arbitro_conversor_bcd.sv
// Round-robin arbiter sharing one binary-to-BCD core among NUM_REQUISITANTES requesters.
// Sequences the core start pulse, waits for its valid strobe and aborts on timeout.
module arbitro_conversor_bcd #(
  parameter int unsigned NUM_REQUISITANTES = 4,
  parameter int unsigned LARGURA_ENTRADA   = 16,
  parameter int unsigned LARGURA_BCD       = 16,
  parameter int unsigned TIMEOUT_CICLOS    = 64
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQUISITANTES-1:0]                 requisicao,
  input  logic [NUM_REQUISITANTES*LARGURA_ENTRADA-1:0] entrada_binaria,
  output logic [LARGURA_ENTRADA-1:0]                   core_entrada,
  output logic                                         core_iniciar,
  input  logic [LARGURA_BCD-1:0]                       core_saida_bcd,
  input  logic                                         core_dados_validos,
  output logic [LARGURA_BCD-1:0]                       saida_bcd,
  output logic [NUM_REQUISITANTES-1:0]                 concluido,
  output logic [NUM_REQUISITANTES-1:0]                 erro_timeout,
  output logic                                         ocupado
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUISITANTES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQUISITANTES - 1);

  typedef enum logic [1:0] {OCIOSO, DISPARO, AGUARDAR} estado_t;

  estado_t                       estado_q, estado_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [IDX_W-1:0]              grant_q, grant_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LARGURA_ENTRADA-1:0]    core_entrada_q, core_entrada_d;
  logic [LARGURA_BCD-1:0]        saida_q, saida_d;
  logic [NUM_REQUISITANTES-1:0]  concluido_q, concluido_d;
  logic [NUM_REQUISITANTES-1:0]  erro_q, erro_d;

  logic [IDX_W-1:0]              sel;
  logic                          achou;
  int unsigned                   cand;
  logic [IDX_W-1:0]              prox_ptr;

  // First pending request at or above the pointer, wrapping past N-1 to 0.
  always_comb begin
    sel   = ptr_q;
    achou = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQUISITANTES; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQUISITANTES;
      if (!achou && requisicao[IDX_W'(cand)]) begin
        achou = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  assign prox_ptr = (grant_q == IDX_MAX) ? '0 : grant_q + 1'b1;

  always_comb begin
    estado_d       = estado_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    core_entrada_d = core_entrada_q;
    saida_d        = saida_q;
    concluido_d    = '0;
    erro_d         = '0;
    case (estado_q)
      OCIOSO: begin
        if (achou) begin
          grant_d        = sel;
          core_entrada_d = entrada_binaria[sel*LARGURA_ENTRADA +: LARGURA_ENTRADA];
          estado_d       = DISPARO;
        end
      end
      DISPARO: begin
        cnt_d    = '0;
        estado_d = AGUARDAR;
      end
      AGUARDAR: begin
        if (core_dados_validos) begin
          saida_d              = core_saida_bcd;
          concluido_d[grant_q] = 1'b1;
          ptr_d                = prox_ptr;
          estado_d             = OCIOSO;
        end else if (cnt_q == CNT_MAX) begin
          erro_d[grant_q] = 1'b1;
          ptr_d           = prox_ptr;
          estado_d        = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      ptr_q          <= '0;
      grant_q        <= '0;
      cnt_q          <= '0;
      core_entrada_q <= '0;
      saida_q        <= '0;
      concluido_q    <= '0;
      erro_q         <= '0;
    end else begin
      estado_q       <= estado_d;
      ptr_q          <= ptr_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      core_entrada_q <= core_entrada_d;
      saida_q        <= saida_d;
      concluido_q    <= concluido_d;
      erro_q         <= erro_d;
    end
  end

  assign core_entrada = core_entrada_q;
  assign core_iniciar = (estado_q == DISPARO);
  assign saida_bcd    = saida_q;
  assign concluido    = concluido_q;
  assign erro_timeout = erro_q;
  assign ocupado      = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_conversor_bcd.sv
// Bench for arbitro_conversor_bcd: core mock with programmable latency, vector table
// for single transactions, and directed sequences for arbitration, timeout and reset.
module tb_arbitro_conversor_bcd;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
  localparam int unsigned B = 16;
  localparam int unsigned T = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   requisicao;
  logic [N*W-1:0] entrada_binaria;
  logic [W-1:0]   core_entrada;
  logic           core_iniciar;
  logic [B-1:0]   core_saida_bcd;
  logic           core_dados_validos;
  logic [B-1:0]   saida_bcd;
  logic [N-1:0]   concluido;
  logic [N-1:0]   erro_timeout;
  logic           ocupado;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  arbitro_conversor_bcd #(
    .NUM_REQUISITANTES(N),
    .LARGURA_ENTRADA(W),
    .LARGURA_BCD(B),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .requisicao(requisicao),
    .entrada_binaria(entrada_binaria),
    .core_entrada(core_entrada),
    .core_iniciar(core_iniciar),
    .core_saida_bcd(core_saida_bcd),
    .core_dados_validos(core_dados_validos),
    .saida_bcd(saida_bcd),
    .concluido(concluido),
    .erro_timeout(erro_timeout),
    .ocupado(ocupado)
  );

  function automatic logic [15:0] bcd(input logic [15:0] v);
    int unsigned x;
    x = 32'(v);
    return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Core mock: valid pulses L cycles after the cycle in which core_iniciar is high.
  logic        mock_on = 1'b1;
  int unsigned lat = 1;
  logic        pend = 1'b0;
  int unsigned rem = 0;
  logic [15:0] op_cap = '0;
  logic        mock_valid = 1'b0;
  logic [15:0] mock_res = '0;
  logic        spur;
  logic [15:0] spur_val;

  assign core_dados_validos = mock_valid | spur;
  assign core_saida_bcd     = mock_valid ? mock_res : spur_val;

  always @(posedge clk) begin
    mock_valid <= 1'b0;
    if (reset) begin
      pend <= 1'b0;
    end else if (core_iniciar && mock_on) begin
      op_cap <= core_entrada;
      if (lat == 1) begin
        mock_valid <= 1'b1;
        mock_res   <= bcd(core_entrada);
        pend       <= 1'b0;
      end else begin
        pend <= 1'b1;
        rem  <= lat - 1;
      end
    end else if (pend) begin
      if (rem == 1) begin
        pend       <= 1'b0;
        mock_valid <= 1'b1;
        mock_res   <= bcd(op_cap);
      end else begin
        rem <= rem - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int unsigned cyc, output logic [N-1:0] c, output logic [N-1:0] e,
                           output int unsigned starts, output logic [15:0] ent1, output logic ini1);
    cyc = 0; c = '0; e = '0; starts = 0; ent1 = '0; ini1 = 1'b0;
    while (cyc < 200 && c == '0 && e == '0) begin
      step();
      cyc++;
      if (core_iniciar) starts++;
      if (cyc == 1) begin
        ini1 = core_iniciar;
        ent1 = core_entrada;
      end
      c = concluido;
      e = erro_timeout;
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [15:0]  op;
    int unsigned  lat;
    logic [N-1:0] exp_c;
    logic [15:0]  exp_bcd;
    int unsigned  exp_cyc;
  } vec_t;

  vec_t         tbl[5];
  logic [15:0]  exp_a[5];
  int unsigned  cyc, starts;
  logic [N-1:0] c, e;
  logic [15:0]  ent1;
  logic         ini1;
  logic         pulso;

  initial begin
    tbl[0] = '{4'b0001, 16'd1234, 18, 4'b0001, 16'h1234, 20};
    tbl[1] = '{4'b0010, 16'd9999,  1, 4'b0010, 16'h9999,  3};
    tbl[2] = '{4'b0100, 16'd4321,  2, 4'b0100, 16'h4321,  4};
    tbl[3] = '{4'b0001, 16'd7,     4, 4'b0001, 16'h0007,  6};
    tbl[4] = '{4'b1000, 16'd0,     5, 4'b1000, 16'h0000,  7};
    exp_a[0] = 16'h9999; exp_a[1] = 16'h0000; exp_a[2] = 16'h0042;
    exp_a[3] = 16'h0500; exp_a[4] = 16'h9999;

    reset = 1'b1; requisicao = '0; entrada_binaria = '0; spur = 1'b0; spur_val = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_core_entrada", 32'(core_entrada), 32'h0);
    chk("rst_core_iniciar", 32'(core_iniciar), 32'h0);
    chk("rst_saida_bcd", 32'(saida_bcd), 32'h0);
    chk("rst_concluido", 32'(concluido), 32'h0);
    chk("rst_erro", 32'(erro_timeout), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);

    for (int i = 0; i < 5; i++) begin
      lat = tbl[i].lat;
      entrada_binaria = '0;
      for (int k = 0; k < int'(N); k++)
        if (tbl[i].req[k]) entrada_binaria[k*W +: W] = tbl[i].op;
      requisicao = tbl[i].req;
      wait_done(cyc, c, e, starts, ent1, ini1);
      requisicao = '0;
      chk("tbl_iniciar_c1", 32'(ini1), 32'h1);
      chk("tbl_core_entrada", 32'(ent1), 32'(tbl[i].op));
      chk("tbl_concluido", 32'(c), 32'(tbl[i].exp_c));
      chk("tbl_erro", 32'(e), 32'h0);
      chk("tbl_latency", cyc, tbl[i].exp_cyc);
      chk("tbl_saida_bcd", 32'(saida_bcd), 32'(tbl[i].exp_bcd));
      chk("tbl_starts", starts, 32'd1);
    end

    // All four requesting: round-robin back-to-back from pointer 0.
    lat = 3;
    entrada_binaria = {16'd500, 16'd42, 16'd0, 16'd9999};
    requisicao = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(cyc, c, e, starts, ent1, ini1);
      if (j == 4) requisicao = '0;
      chk("rr_concluido", 32'(c), 32'(4'b0001 << (j % 4)));
      chk("rr_saida_bcd", 32'(saida_bcd), 32'(exp_a[j]));
      chk("rr_latency", cyc, 32'd5);
      chk("rr_starts", starts, 32'd1);
    end

    // Wrap-around: grant 1 leaves pointer at 2, then 0 beats 1.
    lat = 2;
    entrada_binaria = '0;
    entrada_binaria[0*W +: W] = 16'd11;
    entrada_binaria[1*W +: W] = 16'd22;
    requisicao = 4'b0010;
    wait_done(cyc, c, e, starts, ent1, ini1);
    requisicao = '0;
    chk("wrap_pre", 32'(c), 32'h2);
    requisicao = 4'b0011;
    wait_done(cyc, c, e, starts, ent1, ini1);
    chk("wrap_first", 32'(c), 32'h1);
    chk("wrap_first_bcd", 32'(saida_bcd), 32'h0011);
    wait_done(cyc, c, e, starts, ent1, ini1);
    requisicao = '0;
    chk("wrap_second", 32'(c), 32'h2);
    chk("wrap_second_bcd", 32'(saida_bcd), 32'h0022);

    // Timeout: core never answers.
    mock_on = 1'b0;
    entrada_binaria[2*W +: W] = 16'd77;
    requisicao = 4'b0100;
    wait_done(cyc, c, e, starts, ent1, ini1);
    requisicao = '0;
    chk("to_erro", 32'(e), 32'h4);
    chk("to_concluido", 32'(c), 32'h0);
    chk("to_cycles", cyc, T + 2);
    chk("to_saida_kept", 32'(saida_bcd), 32'h0022);
    step();
    chk("to_erro_1cycle", 32'(erro_timeout), 32'h0);
    mock_on = 1'b1;
    entrada_binaria[2*W +: W] = 16'd300;
    requisicao = 4'b0100;
    wait_done(cyc, c, e, starts, ent1, ini1);
    requisicao = '0;
    chk("after_to_concluido", 32'(c), 32'h4);
    chk("after_to_bcd", 32'(saida_bcd), 32'h0300);

    // Spurious valids in OCIOSO and DISPARO, then requester 1 drops mid-operation.
    spur_val = 16'h7777;
    spur = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("spur_idle_concluido", 32'(concluido), 32'h0);
      chk("spur_idle_bcd", 32'(saida_bcd), 32'h0300);
      chk("spur_idle_ocupado", 32'(ocupado), 32'h0);
    end
    spur = 1'b0;
    lat = 4;
    entrada_binaria[1*W +: W] = 16'd55;
    requisicao = 4'b0010;
    step();
    chk("disparo_iniciar", 32'(core_iniciar), 32'h1);
    spur = 1'b1;
    step();
    spur = 1'b0;
    requisicao = '0;
    chk("spur_disparo_concluido", 32'(concluido), 32'h0);
    chk("spur_disparo_bcd", 32'(saida_bcd), 32'h0300);
    wait_done(cyc, c, e, starts, ent1, ini1);
    chk("drop_concluido", 32'(c), 32'h2);
    chk("drop_cycles", cyc, 32'd4);
    chk("drop_bcd", 32'(saida_bcd), 32'h0055);

    // Reset in AGUARDAR: everything cleared, later valids ignored, pointer back to 0.
    lat = 10;
    entrada_binaria[0*W +: W] = 16'd88;
    requisicao = 4'b0001;
    repeat (4) step();
    chk("mid_ocupado", 32'(ocupado), 32'h1);
    reset = 1'b1;
    requisicao = '0;
    step();
    reset = 1'b0;
    chk("mrst_core_entrada", 32'(core_entrada), 32'h0);
    chk("mrst_iniciar", 32'(core_iniciar), 32'h0);
    chk("mrst_bcd", 32'(saida_bcd), 32'h0);
    chk("mrst_concluido", 32'(concluido), 32'h0);
    chk("mrst_erro", 32'(erro_timeout), 32'h0);
    chk("mrst_ocupado", 32'(ocupado), 32'h0);
    spur_val = 16'h4444;
    spur = 1'b1;
    pulso = 1'b0;
    repeat (2) begin
      step();
      if (concluido != '0 || erro_timeout != '0 || ocupado) pulso = 1'b1;
    end
    spur = 1'b0;
    repeat (12) begin
      step();
      if (concluido != '0 || erro_timeout != '0 || ocupado) pulso = 1'b1;
    end
    chk("post_rst_no_pulse", 32'(pulso), 32'h0);
    chk("post_rst_bcd", 32'(saida_bcd), 32'h0);
    lat = 2;
    entrada_binaria = '0;
    entrada_binaria[0*W +: W] = 16'd1;
    entrada_binaria[3*W +: W] = 16'd2;
    requisicao = 4'b1001;
    wait_done(cyc, c, e, starts, ent1, ini1);
    requisicao = '0;
    chk("post_rst_ptr0", 32'(c), 32'h1);
    chk("post_rst_result", 32'(saida_bcd), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
